spio_spl_bench_receiver: RTL

- Clocked receiving end of the SpiNNaker link NRZ 2-of-7 protocol.
- Synchronises the 7-bit link data, detects complete symbols, toggles the acknowledge and assembles 40/72-bit packets.
- Checks packet parity and framing, then presents each packet on a valid/ready interface.
- Sits opposite `spio_spinnaker_link_sender` in loopback benches and board-level link tests.

---
 rtl/spio_spl_pkg.sv | 53 +++++
 rtl/spio_spinnaker_link_sync.sv | 24 ++
 rtl/spio_spl_bench_receiver.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/spio_spl_pkg.sv
// Shared definitions for the SpiNNaker link 2-of-7 receiver.
// Contents: the 16 data codes and the EOP code, packet length constants,
// packet field positions, the receiver state enum and a symbol decoder.
package spio_spl_pkg;

    localparam int SHORT_NIBBLES = 10;
    localparam int LONG_NIBBLES  = 18;

    // Packet field positions inside the 72-bit packet vector
    localparam int HDR_LSB = 0;
    localparam int HDR_W   = 8;
    localparam int KEY_LSB = 8;
    localparam int KEY_W   = 32;
    localparam int PLD_LSB = 40;
    localparam int PLD_W   = 32;

    localparam logic [6:0] EOP_CODE = 7'b1100000;

    // Entry [i] is the wire pattern that carries nibble value i
    localparam logic [15:0][6:0] DATA_CODES = {
        7'b0001001, 7'b0001100, 7'b0000110, 7'b0000011,
        7'b1001000, 7'b1000100, 7'b1000010, 7'b1000001,
        7'b0101000, 7'b0100100, 7'b0100010, 7'b0100001,
        7'b0011000, 7'b0010100, 7'b0010010, 7'b0010001
    };

    typedef enum logic [2:0] {
        ST_INIT     = 3'd0,
        ST_IDLE     = 3'd1,
        ST_ACK_WAIT = 3'd2,
        ST_HOLD     = 3'd3,
        ST_DROP     = 3'd4
    } state_t;

    typedef struct packed {
        logic       hit;
        logic [3:0] nib;
    } sym_t;

    // Map a wire-change pattern to a data nibble; hit is 0 for anything else
    function automatic sym_t decode_data(input logic [6:0] code);
        sym_t res;
        res = '0;
        for (int i = 0; i < 16; i++) begin
            if (code == DATA_CODES[i]) begin
                res.hit = 1'b1;
                res.nib = 4'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/spio_spinnaker_link_sync.sv
// Two-flop synchroniser for the asynchronous link wires.
// Ports: i_clk clock, i_in asynchronous input bus, o_out synchronised bus.
// The flops are deliberately not reset: they keep following the wires
// through a receiver reset, so the INIT state samples the true wire level
// as its NRZ reference instead of a reset value.
module spio_spinnaker_link_sync #(
    parameter int SIZE = 1
) (
    input  logic            i_clk,
    input  logic [SIZE-1:0] i_in,
    output logic [SIZE-1:0] o_out
);

    logic [SIZE-1:0] r_meta;
    logic [SIZE-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        r_meta <= i_in;
        r_sync <= r_meta;
    end

    assign o_out = r_sync;

endmodule

// File: rtl/spio_spl_bench_receiver.sv
// Receiving end of the SpiNNaker link NRZ 2-of-7 protocol.
// Ports:
//   tb_clk, tb_rst        clock, asynchronous active-high reset
//   SL_DATA_2OF7_IN       asynchronous NRZ link data
//   SL_ACK_OUT            NRZ acknowledge, toggles once per consumed symbol
//   PKT_DATA_OUT          {payload, key, header}; payload zero for short packets
//   PKT_VLD_OUT/RDY_IN    output handshake
//   ERR_PARITY_OUT        one-cycle pulse, delivered packet had even parity
//   ERR_FRAME_OUT         one-cycle pulse, frame dropped
//   PKT_CNT_OUT           delivered packet count
//   o_dbg_state           current FSM state
// Handshake: a packet transfers on every rising clock edge where PKT_VLD_OUT
// and PKT_RDY_IN are both high; while PKT_VLD_OUT is high and PKT_RDY_IN is
// low, PKT_DATA_OUT holds its value.
module spio_spl_bench_receiver
    import spio_spl_pkg::*;
#(
    parameter int ACK_DLY = 8
) (
    input  logic        tb_clk,
    input  logic        tb_rst,
    input  logic [6:0]  SL_DATA_2OF7_IN,
    output logic        SL_ACK_OUT,
    output logic [71:0] PKT_DATA_OUT,
    output logic        PKT_VLD_OUT,
    input  logic        PKT_RDY_IN,
    output logic        ERR_PARITY_OUT,
    output logic        ERR_FRAME_OUT,
    output logic [31:0] PKT_CNT_OUT,
    output logic [2:0]  o_dbg_state
);

    localparam logic [7:0] ACK_LAST = 8'(ACK_DLY - 1);

    state_t      r_state;
    logic [6:0]  r_old_data;
    logic [6:0]  r_diff_prev;
    logic [71:0] r_pkt;
    logic [4:0]  r_fltc;
    logic [7:0]  r_dcnt;
    logic        r_drop_wait;   // DROP: a symbol was taken, ack pending
    logic        r_drop_eop;    // DROP: the pending symbol was an EOP
    logic        r_ack;
    logic        r_vld;
    logic [71:0] r_data;
    logic [31:0] r_cnt;
    logic        r_err_par;
    logic        r_err_frm;

    logic [6:0]  w_sdata;
    logic [6:0]  w_diff;
    logic        w_stable;
    logic        w_multi;
    sym_t        w_sym;
    logic        w_is_data;
    logic        w_is_eop;
    logic        w_is_bad;
    logic        w_long;
    logic        w_complete;
    logic [71:0] w_frame;
    logic        w_par_ok;
    logic        w_hs;
    logic        w_can_load;
    logic        w_load;
    logic [6:0]  w_nib_idx;

    spio_spinnaker_link_sync #(.SIZE(7)) u_sync (
        .i_clk (tb_clk),
        .i_in  (SL_DATA_2OF7_IN),
        .o_out (w_sdata)
    );

    // A symbol is evaluated only once the change pattern has been the same
    // non-zero value for two cycles, so skewed wire edges settle first.
    assign w_diff    = w_sdata ^ r_old_data;
    assign w_stable  = (w_diff != 7'd0) && (w_diff == r_diff_prev);
    assign w_multi   = |(w_diff & (w_diff - 7'd1));
    assign w_sym     = decode_data(w_diff);
    assign w_is_data = w_stable && w_sym.hit;
    assign w_is_eop  = w_stable && (w_diff == EOP_CODE);
    assign w_is_bad  = w_stable && w_multi && !w_sym.hit && (w_diff != EOP_CODE);

    assign w_nib_idx  = {r_fltc, 2'b00};
    assign w_long     = (r_fltc == 5'(LONG_NIBBLES));
    assign w_complete = ((r_fltc == 5'(SHORT_NIBBLES)) && !r_pkt[HDR_LSB + 1]) ||
                        (w_long && r_pkt[HDR_LSB + 1]);

    always_comb begin
        w_frame = '0;
        w_frame[HDR_LSB +: HDR_W] = r_pkt[HDR_LSB +: HDR_W];
        w_frame[KEY_LSB +: KEY_W] = r_pkt[KEY_LSB +: KEY_W];
        if (w_long) begin
            w_frame[PLD_LSB +: PLD_W] = r_pkt[PLD_LSB +: PLD_W];
        end
    end

    // Payload bits are zero for short frames, so one XOR covers both lengths
    assign w_par_ok   = ^w_frame;
    assign w_hs       = r_vld && PKT_RDY_IN;
    assign w_can_load = !r_vld || PKT_RDY_IN;
    assign w_load     = ((r_state == ST_IDLE) && w_is_eop && w_complete && w_can_load) ||
                        ((r_state == ST_HOLD) && w_can_load);

    always_ff @(posedge tb_clk or posedge tb_rst) begin
        if (tb_rst) begin
            r_state     <= ST_INIT;
            r_old_data  <= '0;
            r_diff_prev <= '0;
            r_pkt       <= '0;
            r_fltc      <= '0;
            r_dcnt      <= '0;
            r_drop_wait <= 1'b0;
            r_drop_eop  <= 1'b0;
            r_ack       <= 1'b0;
            r_vld       <= 1'b0;
            r_data      <= '0;
            r_cnt       <= '0;
            r_err_par   <= 1'b0;
            r_err_frm   <= 1'b0;
        end else begin
            r_diff_prev <= w_diff;
            r_err_par   <= 1'b0;
            r_err_frm   <= 1'b0;

            if (w_hs) begin
                r_cnt <= r_cnt + 32'd1;
                r_vld <= 1'b0;
            end
            // A load in the handshake cycle overrides the valid drop above
            if (w_load) begin
                r_vld     <= 1'b1;
                r_data    <= w_frame;
                r_err_par <= !w_par_ok;
            end

            case (r_state)
                ST_INIT: begin
                    r_ack      <= 1'b1;
                    r_old_data <= w_sdata;
                    r_state    <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (w_is_data) begin
                        r_old_data <= w_sdata;
                        r_dcnt     <= '0;
                        if (r_fltc == 5'(LONG_NIBBLES)) begin
                            // Overflow: this symbol is acked from DROP
                            r_err_frm   <= 1'b1;
                            r_drop_wait <= 1'b1;
                            r_drop_eop  <= 1'b0;
                            r_state     <= ST_DROP;
                        end else begin
                            r_pkt[w_nib_idx +: 4] <= w_sym.nib;
                            r_fltc  <= r_fltc + 5'd1;
                            r_state <= ST_ACK_WAIT;
                        end
                    end else if (w_is_eop) begin
                        if (!w_complete) begin
                            r_err_frm  <= 1'b1;
                            r_fltc     <= '0;
                            r_old_data <= w_sdata;
                            r_dcnt     <= '0;
                            r_state    <= ST_ACK_WAIT;
                        end else if (w_can_load) begin
                            r_fltc     <= '0;
                            r_old_data <= w_sdata;
                            r_dcnt     <= '0;
                            r_state    <= ST_ACK_WAIT;
                        end else begin
                            // Leave the EOP unconsumed so the sender stalls
                            r_state <= ST_HOLD;
                        end
                    end else if (w_is_bad) begin
                        r_err_frm   <= 1'b1;
                        r_old_data  <= w_sdata;
                        r_dcnt      <= '0;
                        r_drop_wait <= 1'b1;
                        r_drop_eop  <= 1'b0;
                        r_state     <= ST_DROP;
                    end
                end
                ST_HOLD: begin
                    if (w_can_load) begin
                        r_fltc     <= '0;
                        r_old_data <= w_sdata;
                        r_dcnt     <= '0;
                        r_state    <= ST_ACK_WAIT;
                    end
                end
                ST_ACK_WAIT: begin
                    if (r_dcnt == ACK_LAST) begin
                        r_ack   <= !r_ack;
                        r_state <= ST_IDLE;
                    end else begin
                        r_dcnt <= r_dcnt + 8'd1;
                    end
                end
                ST_DROP: begin
                    if (r_drop_wait) begin
                        if (r_dcnt == ACK_LAST) begin
                            r_ack       <= !r_ack;
                            r_drop_wait <= 1'b0;
                            if (r_drop_eop) begin
                                r_fltc  <= '0;
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_dcnt <= r_dcnt + 8'd1;
                        end
                    end else if (w_stable && w_multi) begin
                        r_old_data  <= w_sdata;
                        r_dcnt      <= '0;
                        r_drop_wait <= 1'b1;
                        r_drop_eop  <= (w_diff == EOP_CODE);
                    end
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    assign SL_ACK_OUT     = r_ack;
    assign PKT_DATA_OUT   = r_data;
    assign PKT_VLD_OUT    = r_vld;
    assign ERR_PARITY_OUT = r_err_par;
    assign ERR_FRAME_OUT  = r_err_frm;
    assign PKT_CNT_OUT    = r_cnt;
    assign o_dbg_state    = r_state;

endmodule
